// File: rtl/fetch_queue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_if : redirect, instruction-memory and IF/ID handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_pc;
  logic [31:0] fq_instruction;

  modport master (
    input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, fq_ready,
    output imem_req_valid, imem_req_addr, fq_valid, fq_pc, fq_instruction
  );

  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, fq_ready,
    input  imem_req_valid, imem_req_addr, fq_valid, fq_pc, fq_instruction
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : fetch PC owner, imem request issue, PC-tagged instruction FIFO
//               with redirect flush. Macro FETCHQ_BYPASS_EN adds empty-FIFO bypass.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq_bus
);
  localparam int              c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW    = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_rsp_pc;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop;
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [31:0]     r_pc_mem  [DEPTH];
  logic [31:0]     r_ins_mem [DEPTH];

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_ok;
  logic            w_rsp_live;
  logic            w_bypass;
  logic            w_fq_valid;
  logic            w_pop;
  logic            w_pop_fifo;
  logic            w_push;
  logic [c_CW-1:0] w_live;
  logic [c_CW:0]   w_commit;
  logic [c_CW-1:0] w_out_next;
  logic [31:0]     w_fq_pc;
  logic [31:0]     w_fq_ins;

  // Live in-flight plus buffered never exceeds DEPTH, so every kept response has a slot.
  assign w_live      = r_outstanding - r_drop;
  assign w_commit    = {1'b0, w_live} + {1'b0, r_count};
  assign w_req_valid = !rst && (r_outstanding < c_DEPTH) && (w_commit < {1'b0, c_DEPTH});
  assign w_req_fire  = w_req_valid && fq_bus.imem_req_ready;
  assign w_rsp_ok    = !rst && fq_bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_live  = w_rsp_ok && (r_drop == '0) && !fq_bus.redirect;

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = (r_count == '0) && w_rsp_live;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fq_valid = !rst && ((r_count != '0) || w_bypass);
  assign w_pop      = w_fq_valid && fq_bus.fq_ready;
  assign w_pop_fifo = w_pop && (r_count != '0) && !fq_bus.redirect;
  assign w_push     = w_rsp_live && !(w_bypass && w_pop);
  assign w_out_next = r_outstanding + c_CW'(w_req_fire) - c_CW'(w_rsp_ok);

  always_comb begin
    w_fq_pc  = '0;
    w_fq_ins = '0;
    if (w_fq_valid) begin
      if (r_count != '0) begin
        w_fq_pc  = r_pc_mem[r_head];
        w_fq_ins = r_ins_mem[r_head];
      end else begin
        w_fq_pc  = r_rsp_pc;
        w_fq_ins = fq_bus.imem_rsp_data;
      end
    end
  end

  assign fq_bus.imem_req_valid = w_req_valid;
  assign fq_bus.imem_req_addr  = rst ? RESET_PC : r_fetch_pc;
  assign fq_bus.fq_valid       = w_fq_valid;
  assign fq_bus.fq_pc          = w_fq_pc;
  assign fq_bus.fq_instruction = w_fq_ins;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (fq_bus.redirect) begin
        // Everything still in flight, including a request accepted this cycle, is stale.
        r_fetch_pc <= {fq_bus.redirect_pc[31:2], 2'b00};
        r_rsp_pc   <= {fq_bus.redirect_pc[31:2], 2'b00};
        r_drop     <= w_out_next;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_rsp_ok && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
        if (w_rsp_live) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop_fifo) begin
          r_head <= r_head + 1'b1;
        end
        if (w_push && !w_pop_fifo) begin
          r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop_fifo) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]  <= r_rsp_pc;
      r_ins_mem[r_tail] <= fq_bus.imem_rsp_data;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop_fifo && (r_count == c_DEPTH)));

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(fq_bus.imem_rsp_valid && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue : directed phases plus random traffic against a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .fq_bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int p_ready = 100, p_fqr = 100, lat_min = 1, lat_max = 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  logic [31:0] seen[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the edge, then let the memory book-keep at the falling edge.
  task automatic tick(input bit do_rst, input bit do_redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    rst               = do_rst;
    bus.redirect      = do_redir;
    bus.redirect_pc   = tgt;
    bus.imem_req_ready = ($urandom_range(99) < p_ready);
    bus.fq_ready      = ($urandom_range(99) < p_fqr);
    if (!do_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    if (do_rst) begin
      mem_q.delete();
    end else begin
      if (bus.imem_rsp_valid) void'(mem_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        mem_q.push_back('{bus.imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    seen.delete();
  endtask

  task automatic chk_seen(input string name, input int idx, input logic [31:0] exp);
    #1;
    if (idx < seen.size()) begin
      chk(name, seen[idx], exp);
    end else begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: only %0d pops seen, expected pc %h at index %0d", name, seen.size(), exp, idx);
    end
  endtask

  // Reference model: in-flight requests tagged live/stale, FIFO of {pc, instruction}.
  typedef struct { logic [31:0] addr; bit live; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  infl_t       m_infl[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fetch = RESET_PC;
  infl_t       m_rsp;
  int          m_live;
  bit          m_rv, m_byp, m_fv, m_req_f, m_pop, m_have_rsp;
  logic [31:0] m_pc, m_ins;

  always @(negedge clk) begin : p_check
    if (rst) begin
      chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      chk("rst_req_addr",  bus.imem_req_addr, RESET_PC);
      chk("rst_fq_valid",  {31'b0, bus.fq_valid}, 32'd0);
      chk("rst_fq_pc",     bus.fq_pc, 32'd0);
      chk("rst_fq_ins",    bus.fq_instruction, 32'd0);
      m_fetch = RESET_PC;
      m_infl.delete();
      m_fifo.delete();
    end else begin
      m_live = 0;
      foreach (m_infl[i]) if (m_infl[i].live) m_live++;
      m_rv       = (m_infl.size() < DEPTH) && (m_live + m_fifo.size() < DEPTH);
      m_have_rsp = bus.imem_rsp_valid && (m_infl.size() > 0);
      m_byp      = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      m_byp = (m_fifo.size() == 0) && m_have_rsp && m_infl[0].live && !bus.redirect;
`endif
      m_fv  = (m_fifo.size() != 0) || m_byp;
      m_pc  = 32'h0;
      m_ins = 32'h0;
      if (m_fifo.size() != 0) begin
        m_pc  = m_fifo[0].pc;
        m_ins = m_fifo[0].ins;
      end else if (m_byp) begin
        m_pc  = m_infl[0].addr;
        m_ins = mem_word(m_infl[0].addr);
      end
      chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, m_rv});
      chk("req_addr",  bus.imem_req_addr, m_fetch);
      chk("fq_valid",  {31'b0, bus.fq_valid}, {31'b0, m_fv});
      if (m_fv) begin
        chk("fq_pc",  bus.fq_pc, m_pc);
        chk("fq_ins", bus.fq_instruction, m_ins);
      end
      if (bus.fq_valid && bus.fq_ready && !bus.redirect) seen.push_back(bus.fq_pc);

      m_req_f = m_rv && bus.imem_req_ready;
      m_pop   = m_fv && bus.fq_ready;
      if (m_have_rsp) m_rsp = m_infl.pop_front();
      if (bus.redirect) begin
        m_fifo.delete();
        foreach (m_infl[i]) m_infl[i].live = 1'b0;
        if (m_req_f) m_infl.push_back('{m_fetch, 1'b0});
        m_fetch = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (m_pop && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (m_have_rsp && m_rsp.live && !(m_byp && m_pop))
          m_fifo.push_back('{m_rsp.addr, mem_word(m_rsp.addr)});
        if (m_req_f) begin
          m_infl.push_back('{m_fetch, 1'b1});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0;  bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.fq_ready = 1'b0;

    // Streaming with a 1-cycle memory.
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    chk("p1_first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("p1_first_req_addr",  bus.imem_req_addr, 32'h0);
    repeat (20) tick(1'b0, 1'b0, 32'h0);
    chk_seen("p1_pc0", 0, 32'h0);
    chk_seen("p1_pc1", 1, 32'h4);
    chk_seen("p1_pc2", 2, 32'h8);

    // Stall until full, then drain.
    p_fqr = 0;
    do_reset();
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    chk("p2_full_valid",     {31'b0, bus.fq_valid}, 32'd1);
    chk("p2_full_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("p2_full_head_pc",   bus.fq_pc, 32'h0);
    chk("p2_full_head_ins",  bus.fq_instruction, mem_word(32'h0));
    p_fqr = 100;
    repeat (12) tick(1'b0, 1'b0, 32'h0);
    chk_seen("p2_pc0", 0, 32'h0);
    chk_seen("p2_pc1", 1, 32'h4);
    chk_seen("p2_pc2", 2, 32'h8);
    chk_seen("p2_pc3", 3, 32'hC);
    chk_seen("p2_pc4", 4, 32'h10);

    // 3-cycle memory, redirect coinciding with a request and a response.
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h100);
    seen.delete();
    repeat (20) tick(1'b0, 1'b0, 32'h0);
    chk_seen("p3_pc0", 0, 32'h100);
    chk_seen("p3_pc1", 1, 32'h104);

    // Unaligned target and address wrap.
    lat_min = 1; lat_max = 3; p_ready = 70;
    do_reset();
    repeat (6) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h203);
    seen.delete();
    repeat (25) tick(1'b0, 1'b0, 32'h0);
    chk_seen("p4_align0", 0, 32'h200);
    chk_seen("p4_align1", 1, 32'h204);
    tick(1'b0, 1'b1, 32'hFFFF_FFF8);
    seen.delete();
    repeat (40) tick(1'b0, 1'b0, 32'h0);
    chk_seen("p4_wrap0", 0, 32'hFFFF_FFF8);
    chk_seen("p4_wrap1", 1, 32'hFFFF_FFFC);
    chk_seen("p4_wrap2", 2, 32'h0000_0000);
    chk_seen("p4_wrap3", 3, 32'h0000_0004);

    // Reset in the middle of a partially filled queue.
    lat_min = 1; lat_max = 1; p_ready = 100; p_fqr = 0;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    chk("p5_prefill_valid", {31'b0, bus.fq_valid}, 32'd1);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("p5_post_fq_valid",  {31'b0, bus.fq_valid}, 32'd0);
    chk("p5_post_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("p5_post_req_addr",  bus.imem_req_addr, RESET_PC);

    // Random traffic: latency, backpressure, redirects and occasional reset.
    lat_min = 1; lat_max = 4; p_ready = 70; p_fqr = 60;
    repeat (3000) begin
      tick($urandom_range(199) == 0, $urandom_range(19) == 0,
           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
